// File: rtl/sram_access_sequencer.sv
// Shares one external SRAM between the SNES (priority) and the MCU (gap filler),
// producing registered SRAM address, data and strobes with fixed-length accesses.
module sram_access_sequencer #(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_W        = 24
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SNES_RD_START,
    input  logic              SNES_WR_START,
    input  logic [ADDR_W-1:0] SNES_ADDR_MAPPED,
    input  logic              SNES_WR_ALLOWED,
    input  logic [7:0]        SNES_WDATA,
    output logic [7:0]        SNES_RDATA,
    output logic              SNES_RVALID,
    output logic              SNES_OVERRUN,
    input  logic              OVERRUN_CLR,
    input  logic              MCU_RRQ,
    input  logic              MCU_WRQ,
    input  logic [ADDR_W-1:0] MCU_ADDR,
    input  logic [7:0]        MCU_WDATA,
    output logic [7:0]        MCU_RDATA,
    output logic              MCU_RDY,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic [7:0]        ROM_DATA_OUT,
    output logic              ROM_DATA_OE,
    input  logic [7:0]        ROM_DATA_IN,
    output logic              ROM_CE_N,
    output logic              ROM_OE_N,
    output logic              ROM_WE_N,
    output logic              BUSY
);

    typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR} state_t;

    localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WE_END = 4'(ACCESS_CYCLES - 2);

    state_t      state, nxt_state;
    logic [3:0]  cnt, nxt_cnt;

    logic              snes_pend, snes_wr_q, snes_allow_q;
    logic [ADDR_W-1:0] snes_addr_q;
    logic [7:0]        snes_data_q;
    logic              mrd_pend, mwr_pend;
    logic [ADDR_W-1:0] mrd_addr_q, mwr_addr_q;
    logic [7:0]        mwr_data_q;
    logic              cur_allow;

    logic              snes_start, snes_req, mrd_req, mwr_req;
    logic              snes_wr_eff, snes_allow_eff;
    logic [ADDR_W-1:0] snes_addr_eff, mrd_addr_eff, mwr_addr_eff;
    logic [7:0]        snes_data_eff, mwr_data_eff;
    logic              take_snes, take_mrd, take_mwr;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_data;
    logic              sel_allow;
    logic              nxt_rd, nxt_drive, nxt_we, last_cycle;

    // A request pulsing this cycle competes as if it were already pending.
    assign snes_start     = SNES_RD_START | SNES_WR_START;
    assign snes_req       = snes_pend | snes_start;
    assign snes_wr_eff    = snes_start ? SNES_WR_START    : snes_wr_q;
    assign snes_allow_eff = snes_start ? SNES_WR_ALLOWED  : snes_allow_q;
    assign snes_addr_eff  = snes_start ? SNES_ADDR_MAPPED : snes_addr_q;
    assign snes_data_eff  = snes_start ? SNES_WDATA       : snes_data_q;
    assign mrd_req        = mrd_pend | MCU_RRQ;
    assign mwr_req        = mwr_pend | MCU_WRQ;
    assign mrd_addr_eff   = mrd_pend ? mrd_addr_q : MCU_ADDR;
    assign mwr_addr_eff   = mwr_pend ? mwr_addr_q : MCU_ADDR;
    assign mwr_data_eff   = mwr_pend ? mwr_data_q : MCU_WDATA;
    assign last_cycle     = (state != IDLE) && (cnt == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 4'd1;
        take_snes = 1'b0;
        take_mrd  = 1'b0;
        take_mwr  = 1'b0;
        sel_addr  = ROM_ADDR;
        sel_data  = ROM_DATA_OUT;
        sel_allow = cur_allow;
        if (state == IDLE || cnt == LAST) begin
            nxt_cnt = '0;
            if (snes_req) begin
                take_snes = 1'b1;
                nxt_state = snes_wr_eff ? SNES_WR : SNES_RD;
                sel_addr  = snes_addr_eff;
                sel_data  = snes_wr_eff ? snes_data_eff : ROM_DATA_OUT;
                sel_allow = snes_wr_eff & snes_allow_eff;
            end else if (mrd_req) begin
                take_mrd  = 1'b1;
                nxt_state = MCU_RD;
                sel_addr  = mrd_addr_eff;
                sel_allow = 1'b0;
            end else if (mwr_req) begin
                take_mwr  = 1'b1;
                nxt_state = MCU_WR;
                sel_addr  = mwr_addr_eff;
                sel_data  = mwr_data_eff;
                sel_allow = 1'b1;
            end else begin
                nxt_state = IDLE;
            end
        end
    end

    // Strobes are registered from the next state so ROM_* never sees request inputs combinationally.
    assign nxt_rd    = (nxt_state == SNES_RD) || (nxt_state == MCU_RD);
    assign nxt_drive = ((nxt_state == SNES_WR) || (nxt_state == MCU_WR)) && sel_allow;
    assign nxt_we    = nxt_drive && (nxt_cnt >= 4'd1) && (nxt_cnt <= WE_END);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ROM_ADDR     <= '0;
            ROM_DATA_OUT <= '0;
            ROM_DATA_OE  <= 1'b0;
            ROM_CE_N     <= 1'b1;
            ROM_OE_N     <= 1'b1;
            ROM_WE_N     <= 1'b1;
            cur_allow    <= 1'b0;
            SNES_RDATA   <= '0;
            SNES_RVALID  <= 1'b0;
            MCU_RDATA    <= '0;
            MCU_RDY      <= 1'b0;
            SNES_OVERRUN <= 1'b0;
            snes_pend    <= 1'b0;
            mrd_pend     <= 1'b0;
            mwr_pend     <= 1'b0;
        end else begin
            ROM_ADDR     <= sel_addr;
            ROM_DATA_OUT <= sel_data;
            ROM_DATA_OE  <= nxt_drive;
            ROM_CE_N     <= (nxt_state == IDLE);
            ROM_OE_N     <= !nxt_rd;
            ROM_WE_N     <= !nxt_we;
            cur_allow    <= sel_allow;
            SNES_RVALID  <= last_cycle && (state == SNES_RD);
            MCU_RDY      <= last_cycle && ((state == MCU_RD) || (state == MCU_WR));
            if (last_cycle && state == SNES_RD) SNES_RDATA <= ROM_DATA_IN;
            if (last_cycle && state == MCU_RD)  MCU_RDATA  <= ROM_DATA_IN;
            if (snes_start && snes_pend) SNES_OVERRUN <= 1'b1;
            else if (OVERRUN_CLR)        SNES_OVERRUN <= 1'b0;
            if (snes_start)           snes_pend <= 1'b1;
            if (take_snes)            snes_pend <= 1'b0;
            if (MCU_RRQ && !mrd_pend) mrd_pend  <= 1'b1;
            if (take_mrd)             mrd_pend  <= 1'b0;
            if (MCU_WRQ && !mwr_pend) mwr_pend  <= 1'b1;
            if (take_mwr)             mwr_pend  <= 1'b0;
        end
    end

    // Pending payloads are qualified by the pending bits, so they need no reset.
    always_ff @(posedge CLK) begin
        if (snes_start) begin
            snes_addr_q  <= SNES_ADDR_MAPPED;
            snes_wr_q    <= SNES_WR_START;
            snes_allow_q <= SNES_WR_ALLOWED;
            snes_data_q  <= SNES_WDATA;
        end
        if (MCU_RRQ && !mrd_pend) mrd_addr_q <= MCU_ADDR;
        if (MCU_WRQ && !mwr_pend) begin
            mwr_addr_q <= MCU_ADDR;
            mwr_data_q <= MCU_WDATA;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed and randomized bench for sram_access_sequencer against a
// transaction-level model of arbitration, access timing and returned data.
module tb_sram_access_sequencer;
    localparam int N  = 4;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          snes_rd, snes_wr, snes_allowed, overrun_clr;
    logic [AW-1:0] snes_addr, mcu_addr;
    logic [7:0]    snes_wdata, mcu_wdata, rom_in;
    logic          mcu_rrq, mcu_wrq;
    logic [7:0]    snes_rdata, mcu_rdata, rom_dout;
    logic          snes_rvalid, snes_overrun, mcu_rdy;
    logic [AW-1:0] rom_addr;
    logic          rom_doe, rom_ce_n, rom_oe_n, rom_we_n, busy;

    always #5 clk = ~clk;

    sram_access_sequencer #(.ACCESS_CYCLES(N), .ADDR_W(AW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .SNES_RD_START(snes_rd), .SNES_WR_START(snes_wr),
        .SNES_ADDR_MAPPED(snes_addr), .SNES_WR_ALLOWED(snes_allowed),
        .SNES_WDATA(snes_wdata), .SNES_RDATA(snes_rdata), .SNES_RVALID(snes_rvalid),
        .SNES_OVERRUN(snes_overrun), .OVERRUN_CLR(overrun_clr),
        .MCU_RRQ(mcu_rrq), .MCU_WRQ(mcu_wrq), .MCU_ADDR(mcu_addr),
        .MCU_WDATA(mcu_wdata), .MCU_RDATA(mcu_rdata), .MCU_RDY(mcu_rdy),
        .ROM_ADDR(rom_addr), .ROM_DATA_OUT(rom_dout), .ROM_DATA_OE(rom_doe),
        .ROM_DATA_IN(rom_in), .ROM_CE_N(rom_ce_n), .ROM_OE_N(rom_oe_n),
        .ROM_WE_N(rom_we_n), .BUSY(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests, the access in flight, expected outputs.
    bit            s_pend, s_wr, s_allow, r_pend, w_pend;
    logic [AW-1:0] s_addr, r_addr, w_addr, c_addr;
    logic [7:0]    s_data, w_data, c_data;
    int            kind;   // 0 none, 1 SNES read, 2 SNES write, 3 MCU read, 4 MCU write
    int            off;
    bit            c_allow;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_dout, e_srdata, e_mrdata;
    logic          e_ce, e_oe, e_we, e_doe, e_svalid, e_rdy, e_ovr, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        snes_rd = 1'b0; snes_wr = 1'b0; mcu_rrq = 1'b0; mcu_wrq = 1'b0; overrun_clr = 1'b0;
    endtask

    task automatic model_reset();
        s_pend = 0; r_pend = 0; w_pend = 0; kind = 0; off = 0; c_allow = 0;
        e_addr = '0; e_dout = '0; e_srdata = '0; e_mrdata = '0;
        e_ce = 1; e_oe = 1; e_we = 1; e_doe = 0; e_svalid = 0; e_rdy = 0; e_ovr = 0; e_busy = 0;
    endtask

    task automatic model_edge();
        bit fin, free, rd, wr;
        fin = (kind != 0) && (off == N - 1);
        free = (kind == 0) || fin;
        e_svalid = 0;
        e_rdy = 0;
        if (fin) begin
            if (kind == 1) begin e_srdata = rom_in; e_svalid = 1; end
            if (kind == 3) begin e_mrdata = rom_in; e_rdy = 1; end
            if (kind == 4) e_rdy = 1;
        end
        if (snes_rd || snes_wr) begin
            if (s_pend) e_ovr = 1;
            else if (overrun_clr) e_ovr = 0;
            s_pend = 1; s_addr = snes_addr; s_wr = snes_wr; s_allow = snes_allowed; s_data = snes_wdata;
        end else if (overrun_clr) e_ovr = 0;
        if (mcu_rrq && !r_pend) begin r_pend = 1; r_addr = mcu_addr; end
        if (mcu_wrq && !w_pend) begin w_pend = 1; w_addr = mcu_addr; w_data = mcu_wdata; end
        if (free) begin
            off = 0;
            if (s_pend) begin
                s_pend = 0; kind = s_wr ? 2 : 1; c_addr = s_addr; c_data = s_data; c_allow = s_wr && s_allow;
            end else if (r_pend) begin
                r_pend = 0; kind = 3; c_addr = r_addr; c_allow = 0;
            end else if (w_pend) begin
                w_pend = 0; kind = 4; c_addr = w_addr; c_data = w_data; c_allow = 1;
            end else kind = 0;
            if (kind != 0) e_addr = c_addr;
            if (kind == 2 || kind == 4) e_dout = c_data;
        end else off++;
        rd = (kind == 1) || (kind == 3);
        wr = (kind == 2) || (kind == 4);
        e_busy = (kind != 0);
        e_ce = (kind == 0);
        e_oe = !rd;
        e_doe = wr && c_allow;
        e_we = !(wr && c_allow && off >= 1 && off <= N - 2);
    endtask

    task automatic check_all();
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ce_n", 32'(rom_ce_n), 32'(e_ce));
        chk("oe_n", 32'(rom_oe_n), 32'(e_oe));
        chk("we_n", 32'(rom_we_n), 32'(e_we));
        chk("data_oe", 32'(rom_doe), 32'(e_doe));
        chk("rom_addr", 32'(rom_addr), 32'(e_addr));
        chk("rom_dout", 32'(rom_dout), 32'(e_dout));
        chk("snes_rvalid", 32'(snes_rvalid), 32'(e_svalid));
        chk("snes_rdata", 32'(snes_rdata), 32'(e_srdata));
        chk("mcu_rdy", 32'(mcu_rdy), 32'(e_rdy));
        chk("mcu_rdata", 32'(mcu_rdata), 32'(e_mrdata));
        chk("overrun", 32'(snes_overrun), 32'(e_ovr));
    endtask

    // One clock: model follows the edge, pulses drop after it, outputs checked at negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        clear_pulses();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_pulses();
        snes_addr = '0; snes_allowed = 1'b0; snes_wdata = '0;
        mcu_addr = '0; mcu_wdata = '0; rom_in = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // SNES read
        snes_rd = 1; snes_addr = 24'h012345; rom_in = 8'hA5;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k <= 4) begin
                chk("rd_oe_low", 32'(rom_oe_n), 32'd0);
                chk("rd_addr", 32'(rom_addr), 32'h012345);
            end else begin
                chk("rd_rvalid", 32'(snes_rvalid), 32'd1);
                chk("rd_rdata", 32'(snes_rdata), 32'hA5);
            end
        end

        // Same-cycle collision: SNES write beats MCU read
        mcu_rrq = 1; mcu_addr = 24'h400000;
        snes_wr = 1; snes_addr = 24'hE00010; snes_wdata = 8'h3C; snes_allowed = 1; rom_in = 8'h5A;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k <= 4) chk("col_we", 32'(rom_we_n), (k == 2 || k == 3) ? 32'd0 : 32'd1);
            if (k == 5) chk("col_mcu_addr", 32'(rom_addr), 32'h400000);
            chk("col_rdy", 32'(mcu_rdy), (k == 9) ? 32'd1 : 32'd0);
        end
        chk("col_mrdata", 32'(mcu_rdata), 32'h5A);

        // Blocked SNES write
        snes_wr = 1; snes_allowed = 0; snes_addr = 24'h000123; snes_wdata = 8'hFF;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("blk_busy", 32'(busy), (k <= 4) ? 32'd1 : 32'd0);
            chk("blk_we", 32'(rom_we_n), 32'd1);
            chk("blk_doe", 32'(rom_doe), 32'd0);
        end

        // Overrun during an MCU write: latest SNES request wins
        mcu_wrq = 1; mcu_addr = 24'h000055; mcu_wdata = 8'h77;
        step();
        snes_rd = 1; snes_addr = 24'h000010;
        step();
        snes_rd = 1; snes_addr = 24'h000020;
        step();
        chk("ovr_set", 32'(snes_overrun), 32'd1);
        step();
        for (int k = 5; k <= 9; k++) begin
            step();
            if (k <= 8) chk("ovr_addr", 32'(rom_addr), 32'h000020);
        end
        chk("ovr_held", 32'(snes_overrun), 32'd1);
        overrun_clr = 1;
        step();
        chk("ovr_clr", 32'(snes_overrun), 32'd0);

        // MCU read and write together: read first, no bubble
        mcu_rrq = 1; mcu_wrq = 1; mcu_addr = 24'h000100; mcu_wdata = 8'h42;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("mm_busy", 32'(busy), (k <= 8) ? 32'd1 : 32'd0);
            chk("mm_rdy", 32'(mcu_rdy), (k == 5 || k == 9) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of an MCU write
        mcu_wrq = 1; mcu_addr = 24'h000300; mcu_wdata = 8'h99;
        for (int k = 1; k <= 3; k++) step();
        chk("rst_pre_we", 32'(rom_we_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ce", 32'(rom_ce_n), 32'd1);
        chk("rst_we", 32'(rom_we_n), 32'd1);
        chk("rst_doe", 32'(rom_doe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("rst_no_rdy", 32'(mcu_rdy), 32'd0);
            chk("rst_idle", 32'(busy), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            snes_rd      = ($urandom_range(0, 9) == 0);
            snes_wr      = !snes_rd && ($urandom_range(0, 9) == 0);
            snes_addr    = AW'($urandom);
            snes_allowed = 1'($urandom_range(0, 1));
            snes_wdata   = 8'($urandom);
            mcu_rrq      = ($urandom_range(0, 7) == 0);
            mcu_wrq      = ($urandom_range(0, 7) == 0);
            mcu_addr     = AW'($urandom);
            mcu_wdata    = 8'($urandom);
            overrun_clr  = ($urandom_range(0, 15) == 0);
            rom_in       = 8'($urandom);
            step();
        end
        repeat (24) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
